// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// disp_scan_ctrl_if : code capture and display-mux signals of disp_scan_ctrl
// Rev 1.0 : initial release
// ============================================================================
interface disp_scan_ctrl_if;
   logic [2:0] act_in;
   logic [1:0] spd_in;
   logic       code_valid;
   logic       sel;
   logic [2:0] act_q;
   logic [1:0] spd_q;
   logic [1:0] dig_en;
   logic       frame_tick;

   modport master (
      output act_in, spd_in, code_valid,
      input  sel, act_q, spd_q, dig_en, frame_tick
   );

   modport slave (
      input  act_in, spd_in, code_valid,
      output sel, act_q, spd_q, dig_en, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// disp_scan_ctrl : two-digit scan controller with blanking gaps and
//                  frame-aligned code commit. Optional macro: DISP_BLINK_EN.
// Rev 1.0 : initial release
// ============================================================================
module disp_scan_ctrl #(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 8,
   parameter int BLINK_FRAMES = 8
) (
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  bus
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   if (CLK_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= CLK_DIV || BLINK_FRAMES < 1)
   begin : g_param_check
      $error("disp_scan_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      BLANK_S2A = 2'd0,
      SHOW_ACT  = 2'd1,
      BLANK_A2S = 2'd2,
      SHOW_SPD  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             sel_q, sel_d;
   logic [1:0]       dig_en_q, dig_en_d;
   logic             frame_tick_q, frame_tick_d;
   logic [2:0]       act_q, act_d, shadow_act_q, shadow_act_d;
   logic [1:0]       spd_q, spd_d, shadow_spd_q, shadow_spd_d;
   logic             pending_q, pending_d;
   logic             boundary;
   logic             act_dark;

`ifdef DISP_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
`endif

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q + CNT_W'(1);
      boundary     = 1'b0;
      act_d        = act_q;
      spd_d        = spd_q;
      shadow_act_d = shadow_act_q;
      shadow_spd_d = shadow_spd_q;
      pending_d    = pending_q;
      act_dark     = 1'b0;

      case (state_q)
         BLANK_S2A: if (phase_q == BLANK_LAST) state_d = SHOW_ACT;
         SHOW_ACT:  if (phase_q == SHOW_LAST)  state_d = BLANK_A2S;
         BLANK_A2S: if (phase_q == BLANK_LAST) state_d = SHOW_SPD;
         SHOW_SPD: begin
            if (phase_q == SHOW_LAST) begin
               state_d  = BLANK_S2A;
               boundary = 1'b1;
            end
         end
         default:   state_d = BLANK_S2A;
      endcase
      if (state_d != state_q) phase_d = '0;

      // A strobe on the boundary edge bypasses the shadow so it is never a frame late.
      if (boundary) begin
         if (bus.code_valid) begin
            act_d        = bus.act_in;
            spd_d        = bus.spd_in;
            shadow_act_d = bus.act_in;
            shadow_spd_d = bus.spd_in;
            pending_d    = 1'b0;
         end else if (pending_q) begin
            act_d     = shadow_act_q;
            spd_d     = shadow_spd_q;
            pending_d = 1'b0;
         end
      end else if (bus.code_valid) begin
         shadow_act_d = bus.act_in;
         shadow_spd_d = bus.spd_in;
         pending_d    = 1'b1;
      end

`ifdef DISP_BLINK_EN
      blink_cnt_d = blink_cnt_q;
      if (boundary && (act_d != act_q))
         blink_cnt_d = BLINK_W'(BLINK_FRAMES);
      else if (boundary && (blink_cnt_q != '0))
         blink_cnt_d = blink_cnt_q - BLINK_W'(1);
      act_dark = (blink_cnt_d != '0) && blink_cnt_d[0];
`endif

      // Outputs follow the next state so they are registered yet aligned to it.
      frame_tick_d = boundary;
      sel_d        = (state_d == BLANK_A2S) || (state_d == SHOW_SPD);
      case (state_d)
         SHOW_ACT: dig_en_d = act_dark ? 2'b11 : 2'b10;
         SHOW_SPD: dig_en_d = 2'b01;
         default:  dig_en_d = 2'b11;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BLANK_S2A;
         phase_q      <= '0;
         sel_q        <= 1'b0;
         dig_en_q     <= 2'b11;
         frame_tick_q <= 1'b0;
         act_q        <= '0;
         spd_q        <= '0;
         shadow_act_q <= '0;
         shadow_spd_q <= '0;
         pending_q    <= 1'b0;
`ifdef DISP_BLINK_EN
         blink_cnt_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         sel_q        <= sel_d;
         dig_en_q     <= dig_en_d;
         frame_tick_q <= frame_tick_d;
         act_q        <= act_d;
         spd_q        <= spd_d;
         shadow_act_q <= shadow_act_d;
         shadow_spd_q <= shadow_spd_d;
         pending_q    <= pending_d;
`ifdef DISP_BLINK_EN
         blink_cnt_q  <= blink_cnt_d;
`endif
      end
   end

   assign bus.sel        = sel_q;
   assign bus.dig_en     = dig_en_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.act_q      = act_q;
   assign bus.spd_q      = spd_q;

endmodule
`default_nettype wire
